// File: rtl/battery_hud_pkg.sv
// Shared types and constants for the battery HUD sprite sequencer.
package battery_hud_pkg;

    typedef enum logic {SHOW, ANIM} lvl_state_e;

    typedef logic [3:0] level_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int FRAME_WORDS = 512;
    localparam int ADDR_W      = 13;

    function automatic level_t clamp_level(input logic [3:0] v, input level_t max_lvl);
        return (v > max_lvl) ? max_lvl : v;
    endfunction

endpackage

// File: rtl/battery_level_seq.sv
// Charge target/level registers, level FSM and low-charge blink timer.
// BATTERY_CHARGE_ANIM_EN compiles in the +1-per-ANIM_FRAMES ramp on increases.
module battery_level_seq
    import battery_hud_pkg::*;
#(
    parameter int MAX_LEVEL    = 8,
    parameter int LOW_THRESH   = 2,
    parameter int BLINK_FRAMES = 15,
    parameter int ANIM_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [3:0] charge_in,
    input  logic       charge_valid,
    output level_t     level,
    output logic       visible
);

    localparam level_t     MAX_L    = level_t'(MAX_LEVEL);
    localparam level_t     LOW_L    = level_t'(LOW_THRESH);
    localparam logic [3:0] BLINK_M1 = 4'(BLINK_FRAMES - 1);

    level_t     target_q, target_d, tgt_eff;
    level_t     level_q, level_d;
    lvl_state_e state_q, state_d;
    logic [3:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;
`ifdef BATTERY_CHARGE_ANIM_EN
    localparam logic [3:0] ANIM_M1 = 4'(ANIM_FRAMES - 1);
    logic [3:0] anim_cnt_q, anim_cnt_d;
`endif

    always_comb begin
        // a tick in the same cycle as charge_valid sees the new target
        tgt_eff     = charge_valid ? clamp_level(charge_in, MAX_L) : target_q;
        target_d    = tgt_eff;
        level_d     = level_q;
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
`ifdef BATTERY_CHARGE_ANIM_EN
        anim_cnt_d  = anim_cnt_q;
`endif
        if (frame_tick) begin
            case (state_q)
                ANIM: begin
`ifdef BATTERY_CHARGE_ANIM_EN
                    if (tgt_eff <= level_q) begin
                        level_d = tgt_eff;
                        state_d = SHOW;
                    end else if (anim_cnt_q >= ANIM_M1) begin
                        level_d    = level_t'(level_q + 4'd1);
                        anim_cnt_d = '0;
                        if (level_t'(level_q + 4'd1) == tgt_eff) state_d = SHOW;
                    end else begin
                        anim_cnt_d = anim_cnt_q + 4'd1;
                    end
`else
                    level_d = tgt_eff;
                    state_d = SHOW;
`endif
                end
                default: begin
`ifdef BATTERY_CHARGE_ANIM_EN
                    // the entering tick counts as the first of the step
                    if (tgt_eff > level_q) begin
                        state_d    = ANIM;
                        anim_cnt_d = 4'd1;
                    end else begin
                        level_d = tgt_eff;
                    end
`else
                    level_d = tgt_eff;
`endif
                end
            endcase
        end

        if (level_q > LOW_L) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_M1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q    <= '0;
            level_q     <= '0;
            state_q     <= SHOW;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
`ifdef BATTERY_CHARGE_ANIM_EN
            anim_cnt_q  <= '0;
`endif
        end else begin
            target_q    <= target_d;
            level_q     <= level_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`ifdef BATTERY_CHARGE_ANIM_EN
            anim_cnt_q  <= anim_cnt_d;
`endif
        end
    end

    assign level   = level_q;
    assign visible = phase_q | (level_q > LOW_L);

endmodule

// File: rtl/battery_hud_ctrl.sv
// Battery HUD sprite sequencer: raster hit/address pipeline, ROM/palette hookup, keyed RGB.
// BATTERY_CHARGE_ANIM_EN enables the charging ramp inside battery_level_seq.
module battery_hud_ctrl
    import battery_hud_pkg::*;
#(
    parameter int X_POS        = 560,
    parameter int Y_POS        = 16,
    parameter int SPR_W        = 32,
    parameter int SPR_H        = 16,
    parameter int MAX_LEVEL    = 8,
    parameter int LOW_THRESH   = 2,
    parameter int BLINK_FRAMES = 15,
    parameter int ANIM_FRAMES  = 4,
    parameter int TRANSP_IDX   = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_tick,
    input  logic [3:0]        charge_in,
    input  logic              charge_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic              sprite_on,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam logic [9:0]        X_LO     = 10'(X_POS);
    localparam logic [9:0]        X_HI     = 10'(X_POS + SPR_W);
    localparam logic [9:0]        Y_LO     = 10'(Y_POS);
    localparam logic [9:0]        Y_HI     = 10'(Y_POS + SPR_H);
    localparam logic [ADDR_W-1:0] FRAME_L  = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] SPR_W_L  = ADDR_W'(SPR_W);
    localparam logic [3:0]        TRANSP_L = 4'(TRANSP_IDX);

    level_t            level;
    logic              visible;
    logic              hit;
    logic [ADDR_W-1:0] off_x, off_y;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:1]        vld_pipe_q, vld_pipe_d;
    logic              sprite_on_q, sprite_on_d;
    rgb_t              rgb_q, rgb_d;

    battery_level_seq #(
        .MAX_LEVEL   (MAX_LEVEL),
        .LOW_THRESH  (LOW_THRESH),
        .BLINK_FRAMES(BLINK_FRAMES),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_level_seq (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .frame_tick  (frame_tick),
        .charge_in   (charge_in),
        .charge_valid(charge_valid),
        .level       (level),
        .visible     (visible)
    );

    assign pal_index = rom_data;

    always_comb begin
        hit   = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
        off_x = ADDR_W'(DrawX) - ADDR_W'(X_POS);
        off_y = ADDR_W'(DrawY) - ADDR_W'(Y_POS);
        // off-sprite pixels leave the address parked on the last fetch
        addr_d = addr_q;
        if (hit) addr_d = ADDR_W'(level) * FRAME_L + off_y * SPR_W_L + off_x;
        vld_pipe_d  = {vld_pipe_q[1], hit};
        sprite_on_d = vld_pipe_q[2] && visible && (rom_data != TRANSP_L);
        rgb_d       = '0;
        if (sprite_on_d) rgb_d = '{r: pal_red, g: pal_green, b: pal_blue};
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            addr_q      <= '0;
            vld_pipe_q  <= '0;
            sprite_on_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            vld_pipe_q  <= vld_pipe_d;
            sprite_on_q <= sprite_on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rom_addr  = addr_q;
    assign sprite_on = sprite_on_q;
    assign red       = rgb_q.r;
    assign green     = rgb_q.g;
    assign blue      = rgb_q.b;

endmodule

// File: tb/tb_battery_hud_ctrl.sv
// Scoreboard bench for battery_hud_ctrl: ROM and palette modelled here, pixels checked 3 clocks after sampling.
module tb_battery_hud_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        frame_tick = 1'b0;
    logic [3:0]  charge_in = '0;
    logic        charge_valid = 1'b0;
    logic [12:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
    logic        sprite_on;
    logic [3:0]  red, green, blue;

    battery_hud_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_tick(frame_tick), .charge_in(charge_in), .charge_valid(charge_valid),
        .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .sprite_on(sprite_on), .red(red), .green(green), .blue(blue)
    );

    always #5 Clk = ~Clk;

    // palette: index 3 -> A,B,C
    assign pal_red   = pal_index + 4'd7;
    assign pal_green = pal_index + 4'd8;
    assign pal_blue  = pal_index + 4'd9;

    logic       force_en = 1'b0;
    logic [3:0] force_val = '0;
    always @(posedge Clk) rom_data <= force_en ? force_val : rom_addr[3:0];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        son;
        logic [11:0] rgb;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_err = 0;
    int m_level = 0, m_target = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("pix_on", {31'd0, sprite_on}, {31'd0, e.son});
            chk("pix_rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
        end
    end

    // drive one pixel and queue what must come out three clocks later
    task automatic px(input int x, input int y, input bit vis);
        bit         hit;
        logic [12:0] a;
        logic [3:0]  d;
        exp_t        e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        hit   = (x >= 560) && (x < 592) && (y >= 16) && (y < 32);
        a     = 13'(m_level * 512 + (y - 16) * 32 + (x - 560));
        d     = force_en ? force_val : a[3:0];
        e.due = cyc + 3;
        e.son = hit && vis && (d != 4'd2);
        e.rgb = e.son ? {d + 4'd7, d + 4'd8, d + 4'd9} : 12'h000;
        sbq.push_back(e);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        DrawX = '0;
        DrawY = '0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic load(input int c);
        charge_valid = 1'b1;
        charge_in    = 4'(c);
        m_target     = (c > 8) ? 8 : c;
        @(negedge Clk);
        charge_valid = 1'b0;
    endtask

    task automatic tick(input bit v, input int c);
        idle(3);
        frame_tick   = 1'b1;
        charge_valid = v;
        charge_in    = 4'(c);
        if (v) m_target = (c > 8) ? 8 : c;
        m_level = m_target;
        @(negedge Clk);
        frame_tick   = 1'b0;
        charge_valid = 1'b0;
    endtask

    // rom_addr one clock after presenting (x,y), outside the scoreboard
    task automatic addr_at(input string tag, input int x, input int y, input int exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        chk(tag, {19'd0, rom_addr}, 32'(exp));
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_on", {31'd0, sprite_on}, 32'd0);
        chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        chk("rst_addr", {19'd0, rom_addr}, 32'd0);
        Reset_n = 1'b1;
        px(560, 16, 1'b1);
        chk("rst_level", {19'd0, rom_addr}, 32'd0);
        idle(3);

`ifndef BATTERY_CHARGE_ANIM_EN
        load(5);
        tick(1'b0, 0);
        px(560, 16, 1'b1);
        chk("addr_l5", {19'd0, rom_addr}, 32'd2560);
        idle(3);

        force_en = 1'b1; force_val = 4'd2;
        px(560, 16, 1'b1);
        px(575, 20, 1'b1);
        idle(3);
        force_val = 4'd3;
        px(560, 16, 1'b1);
        idle(2);
        chk("key_on", {31'd0, sprite_on}, 32'd1);
        chk("rgb_abc", {20'd0, red, green, blue}, 32'h0ABC);
        idle(2);
        force_en = 1'b0;
        idle(2);

        // edges of the sprite window, back to back
        px(559, 16, 1'b1);
        px(560, 15, 1'b1);
        px(560, 16, 1'b1);
        px(591, 31, 1'b1);
        chk("addr_corner", {19'd0, rom_addr}, 32'd3071);
        px(592, 31, 1'b1);
        chk("addr_hold", {19'd0, rom_addr}, 32'd3071);
        px(591, 32, 1'b1);
        px(575, 23, 1'b1);
        idle(3);

        tick(1'b1, 1);
        for (int k = 1; k <= 45; k++) begin
            tick(1'b0, 0);
            px(570, 20, !((k >= 15 && k <= 29) || k >= 45));
        end
        tick(1'b1, 3);
        px(570, 20, 1'b1);
        chk("addr_l3", {19'd0, rom_addr}, 32'd1674);
        idle(3);

        tick(1'b1, 12);
        px(560, 16, 1'b1);
        chk("addr_clamp", {19'd0, rom_addr}, 32'd4096);
        idle(4);
`else
        load(8);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 0);
            if (k == 31) addr_at("ramp_31", 560, 16, 3584);
            if (k == 32) addr_at("ramp_32", 560, 16, 4096);
        end
        tick(1'b1, 0);
        addr_at("drop_0", 560, 16, 0);
        load(8);
        for (int k = 1; k <= 14; k++) tick(1'b0, 0);
        addr_at("ramp_14", 560, 16, 1536);
        tick(1'b1, 2);
        addr_at("drop_2", 560, 16, 1024);
        tick(1'b1, 12);
        for (int k = 1; k <= 4; k++) tick(1'b0, 0);
        addr_at("clamp_ramp", 560, 16, 1536);
        idle(4);
`endif

        DrawX = 10'd570;
        DrawY = 10'd20;
        repeat (3) @(negedge Clk);
`ifndef BATTERY_CHARGE_ANIM_EN
        chk("pre_rst_on", {31'd0, sprite_on}, 32'd1);
`endif
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("mid_rst_on", {31'd0, sprite_on}, 32'd0);
        chk("mid_rst_rgb", {20'd0, red, green, blue}, 32'd0);
        Reset_n = 1'b1;
        m_level = 0;
        m_target = 0;
        @(negedge Clk);
        chk("stale_1", {31'd0, sprite_on}, 32'd0);
        @(negedge Clk);
        chk("stale_2", {31'd0, sprite_on}, 32'd0);
        @(negedge Clk);
        chk("post_rst_on", {31'd0, sprite_on}, 32'd1);
        chk("post_rst_rgb", {20'd0, red, green, blue}, 32'h0123);
        idle(4);

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
